// File: rtl/mac_lanes_if.sv
// Operand and result streams of the multi-lane MAC engine.
// The master side feeds A/B beats and accepts results; the slave side is the engine.
interface mac_lanes_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LANES      = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*DATA_WIDTH-1:0]  a_vec;
    logic [DATA_WIDTH-1:0]        b;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*ACC_WIDTH-1:0]   c_vec;

    modport master (
        output in_valid, a_vec, b, out_ready,
        input  in_ready, out_valid, c_vec
    );

    modport slave (
        input  in_valid, a_vec, b, out_ready,
        output in_ready, out_valid, c_vec
    );
endinterface

// File: rtl/mac_lanes.sv
// Multi-lane multiply-accumulate engine: each lane multiplies its own A element
// by a broadcast B over a programmed number of terms, with saturating accumulation.
// Pipeline: beat accepted -> product register -> accumulator (one edge later).

// One MAC lane: product register followed by a saturating accumulator.
module mac_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic                  i_acc_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0]  o_acc,
    output logic                  o_sat
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    logic [PW-1:0]        w_as, w_bs, w_prod, r_prod;
    logic [ACC_WIDTH-1:0] w_ext, w_sat_val, r_acc;
    logic [SW-1:0]        w_sum;
    logic                 w_ovf;
    logic                 r_sat;

    // Operands are widened to the full product width first so the low PW bits
    // of the multiply are correct for either arithmetic mode.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_as      = PW'($signed(i_a));
            assign w_bs      = PW'($signed(i_b));
            assign w_ext     = ACC_WIDTH'($signed(r_prod));
            assign w_sum     = SW'($signed(r_acc)) + SW'($signed(w_ext));
            // Overflow when the extra sign bit disagrees with the result sign.
            assign w_ovf     = w_sum[SW-1] ^ w_sum[SW-2];
            assign w_sat_val = w_sum[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin : g_unsigned
            assign w_as      = PW'(i_a);
            assign w_bs      = PW'(i_b);
            assign w_ext     = ACC_WIDTH'(r_prod);
            assign w_sum     = SW'(r_acc) + SW'(w_ext);
            assign w_ovf     = w_sum[SW-1];
            assign w_sat_val = '1;
        end
    endgenerate

    assign w_prod = w_as * w_bs;

    // Product capture on accepted beats; saturating add whenever a fresh product is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_acc  <= '0;
            r_sat  <= 1'b0;
        end else if (i_clr) begin
            r_prod <= '0;
            r_acc  <= '0;
            r_sat  <= 1'b0;
        end else begin
            if (i_load)
                r_prod <= w_prod;
            if (i_acc_en) begin
                r_acc <= w_ovf ? w_sat_val : w_sum[ACC_WIDTH-1:0];
                if (w_ovf)
                    r_sat <= 1'b1;
            end
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;
endmodule

module mac_lanes #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LANES      = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int SIGNED     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_clr,
    input  logic [LEN_WIDTH-1:0] i_len,
    mac_lanes_if.slave           bus,
    output logic [LANES-1:0]     o_sat_flag,
    output logic                 o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t                            r_state, w_next;
    logic [LEN_WIDTH-1:0]              r_len, r_cnt;
    logic                              r_prod_vld;
    logic                              w_in_ready, w_out_valid, w_busy;
    logic                              w_beat, w_last, w_start, w_lane_clr;
    logic [LANES-1:0][ACC_WIDTH-1:0]   w_acc;
    logic [LANES-1:0]                  w_sat;

    assign w_beat     = bus.in_valid && w_in_ready;
    assign w_last     = w_beat && (r_cnt == (r_len - LEN_WIDTH'(1)));
    assign w_start    = (r_state == S_IDLE) && i_start;
    // A new job and an abort both wipe the lanes; clr also wins over start in the FSM.
    assign w_lane_clr = i_clr || w_start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else if (i_clr)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; a zero-length job goes straight to DONE with cleared sums.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (i_len == '0) ? S_DONE : S_ACCUM;
            S_ACCUM: if (w_last) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        w_in_ready  = (r_state == S_ACCUM);
        w_out_valid = (r_state == S_DONE);
        w_busy      = (r_state != S_IDLE);
    end

    // Job length, term counter and the product-valid stage bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_cnt      <= '0;
            r_prod_vld <= 1'b0;
        end else if (i_clr) begin
            r_len      <= '0;
            r_cnt      <= '0;
            r_prod_vld <= 1'b0;
        end else if (w_start) begin
            r_len      <= i_len;
            r_cnt      <= '0;
            r_prod_vld <= 1'b0;
        end else begin
            r_prod_vld <= w_beat;
            if (w_beat)
                r_cnt <= r_cnt + LEN_WIDTH'(1);
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            mac_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .SIGNED     (SIGNED)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_clr    (w_lane_clr),
                .i_load   (w_beat),
                .i_acc_en (r_prod_vld),
                .i_a      (bus.a_vec[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_b      (bus.b),
                .o_acc    (w_acc[g]),
                .o_sat    (w_sat[g])
            );
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.c_vec     = w_acc;
    assign o_sat_flag    = w_sat;
    assign o_busy        = w_busy;
endmodule

// File: doc/mac_lanes.md
Name: mac_lanes

Overview:
Parametrised multi-lane multiply-accumulate engine, the vector successor to the single-channel MAC. LANES independent accumulators each multiply their own A element by a broadcast B operand over a programmed number of terms. Operands arrive on a valid/ready stream; results leave on a valid/ready stream. It serves as the compute core for matrix-vector products, fed by the operand FIFOs and drained by the result writer.

Parameters:
DATA_WIDTH, 8, operand width (A elements and B)
ACC_WIDTH, 24, accumulator and result width per lane; must be >= 2*DATA_WIDTH
LANES, 8, number of parallel MAC lanes
LEN_WIDTH, 8, width of the term-count field
SIGNED, 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a job when the FSM is in IDLE
clr  input  1  synchronous abort; clears all state and returns the FSM to IDLE
len  input  LEN_WIDTH  number of terms; sampled on start
in_valid  input  1  operand beat valid
in_ready  output  1  engine accepts a beat
a_vec  input  LANES*DATA_WIDTH  per-lane A operands; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
b  input  DATA_WIDTH  B operand, broadcast to all lanes
out_valid  output  1  results valid
out_ready  input  1  consumer accepts results
c_vec  output  LANES*ACC_WIDTH  per-lane accumulated results; lane i at [i*ACC_WIDTH +: ACC_WIDTH]
sat_flag  output  LANES  sticky per-lane saturation indicator
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; accumulators, product registers, prod_valid, term counter and sat_flag all 0. Outputs: in_ready=0, out_valid=0, busy=0, c_vec=0, sat_flag=0.
- FSM has four states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 with len!=0: clear accumulators, sat_flag and prod_valid; latch len; counter=0; next state ACCUM.
  - start=1 with len==0: clear accumulators and sat_flag; next state DONE (results all zero).
- ACCUM:
  - in_ready=1.
  - Beat accepted on an edge where in_valid && in_ready.
  - On each accepted beat: product register[i] <= a_i*b (2*DATA_WIDTH, signed or unsigned per SIGNED); prod_valid<=1; counter++.
  - prod_valid<=0 on an edge with no accepted beat.
- Accumulate stage: on any edge where prod_valid=1, acc[i] <= sat(acc[i] + ext(product[i])).
  - ext = zero-extension (SIGNED=0) or sign-extension (SIGNED=1) to ACC_WIDTH.
  - A stale or idle product is never added.
- When the beat bringing the counter to len is accepted, next state is DRAIN.
- DRAIN: in_ready=0; final product is added; next state DONE.
- Latency: last beat accepted on edge k; c_vec final and out_valid=1 from edge k+1.
- DONE:
  - out_valid=1; c_vec is held stable.
  - Leaves on an edge where out_ready=1; next state IDLE, out_valid=0.
  - c_vec and sat_flag keep their values in IDLE until the next start.
- Saturation:
  - Unsigned: clamp to 2^ACC_WIDTH-1.
  - Signed: clamp to +max or -min of ACC_WIDTH.
  - Saturating lane sets sat_flag[i]=1, which stays set until the next start, clr or reset.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored (in_ready=0).
- in_valid gaps in ACCUM only stall; the term count is unaffected.
- clr: highest priority after reset; same clearing as reset, synchronous, in any state. Overrides start in the same cycle.
- Reset or clr mid-job discards partial sums; no out_valid is produced for the aborted job.

Test Plan:
- Basic (defaults): start, len=4; a_i=i+1, b=2 for 4 beats back-to-back -> out_valid one edge after the 4th beat; c_i=8*(i+1) (8,16,...,64); sat_flag=0.
- Backpressure: same job with in_valid low for 3 cycles between beats 2 and 3, and out_ready held low 5 cycles -> identical results; c_vec stable while out_valid=1 and out_ready=0; in_ready=0 in DRAIN and DONE.
- Saturation (ACC_WIDTH=17): len=3, all a=255, b=255 -> c_i=131071 (0x1FFFF); sat_flag=all ones; next start clears sat_flag.
- Signed (SIGNED=1): len=2, a=0x80 (-128), b=127 -> c_i=24'hFF8100 (-32512).
- Zero length / abort: start with len=0 -> out_valid next cycle with c_vec=0. Separately, clr after 2 of 4 beats -> IDLE, c_vec=0, no out_valid. Repeat the 2-of-4 abort using rst_n low -> same result.
- Ignored start: pulse start during ACCUM with len=9 -> original len=4 job completes unaffected.
